proc_ni_bridge: RTL



---
 rtl/noc_ni_pkg.sv | 24 ++
 rtl/ni_sync_fifo.sv | 63 ++++++
 rtl/proc_ni_bridge.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/noc_ni_pkg.sv
// Shared NoC flit definitions: default field widths, flit layout offsets and
// the RX write-source selector used by the processor/NI bridge.
package noc_ni_pkg;

   localparam int unsigned NOC_DATA_W = 32;
   localparam int unsigned NOC_ADDR_W = 2;

   // Flit layout on the router side: {src, dest, data}, data in the LSBs.
   localparam int unsigned FLIT_DATA_LSB = 0;
   localparam int unsigned FLIT_DEST_LSB = FLIT_DATA_LSB + NOC_DATA_W;
   localparam int unsigned FLIT_SRC_LSB  = FLIT_DEST_LSB + NOC_ADDR_W;
   localparam int unsigned FLIT_W        = FLIT_SRC_LSB + NOC_ADDR_W;

   typedef enum logic [1:0] {
      RxSelNone = 2'd0,
      RxSelNet  = 2'd1,
      RxSelLoop = 2'd2
   } rx_sel_e;

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty/level status.
// Push when full and pop when empty are ignored.
module ni_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_level;

   logic w_push;
   logic w_pop;

   assign full    = (r_level == FULL_LEVEL);
   assign empty   = (r_level == '0);
   assign level   = r_level;
   assign rdata   = r_mem[r_rptr];
   assign w_push  = push && !full;
   assign w_pop   = pop && !empty;

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + (PTR_W + 1)'(1);
         end else if (w_pop && !w_push) begin
            r_level <= r_level - (PTR_W + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= wdata;
      end
   end

endmodule

// File: rtl/proc_ni_bridge.sv
// Buffered bridge between the core's NI outputs and the router port, with
// independent TX/RX FIFOs and a loopback path for self-addressed words.
module proc_ni_bridge
   import noc_ni_pkg::*;
#(
   parameter int unsigned DATA_W   = NOC_DATA_W,
   parameter int unsigned ADDR_W   = NOC_ADDR_W,
   parameter int unsigned TX_DEPTH = 4,
   parameter int unsigned RX_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W-1:0]           current_node,
   input  logic                        proc_valid,
   output logic                        proc_ready,
   input  logic [ADDR_W-1:0]           proc_dest,
   input  logic [DATA_W-1:0]           proc_data,
   output logic                        ni_valid,
   input  logic                        ni_ready,
   output logic [ADDR_W-1:0]           ni_dest,
   output logic [ADDR_W-1:0]           ni_src,
   output logic [DATA_W-1:0]           ni_data,
   input  logic                        net_valid,
   output logic                        net_ready,
   input  logic [ADDR_W-1:0]           net_src,
   input  logic [DATA_W-1:0]           net_data,
   output logic                        rx_valid,
   input  logic                        rx_pop,
   output logic [ADDR_W-1:0]           rx_src,
   output logic [DATA_W-1:0]           rx_data,
   output logic [$clog2(TX_DEPTH):0]   tx_level,
   output logic [$clog2(RX_DEPTH):0]   rx_level
);

   localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

   logic [ENTRY_W-1:0] w_tx_wdata;
   logic [ENTRY_W-1:0] w_tx_rdata;
   logic               w_tx_push;
   logic               w_tx_pop;
   logic               w_tx_full;
   logic               w_tx_empty;

   logic [ENTRY_W-1:0] w_rx_wdata;
   logic [ENTRY_W-1:0] w_rx_rdata;
   logic               w_rx_push;
   logic               w_rx_pop;
   logic               w_rx_full;
   logic               w_rx_empty;

   logic [ADDR_W-1:0]  w_head_dest;
   logic [DATA_W-1:0]  w_head_data;
   logic               w_head_local;
   logic               w_net_write;
   logic               w_loop_move;
   rx_sel_e            w_rx_sel;

   // TX path: proc_ready depends only on stored state, never on ni_ready.
   assign proc_ready  = rst && !w_tx_full;
   assign w_tx_push   = proc_valid && proc_ready;
   assign w_tx_wdata  = {proc_dest, proc_data};

   assign w_head_dest  = w_tx_rdata[DATA_W +: ADDR_W];
   assign w_head_data  = w_tx_rdata[DATA_W-1:0];
   assign w_head_local = rst && !w_tx_empty && (w_head_dest == current_node);

   assign ni_valid = rst && !w_tx_empty && (w_head_dest != current_node);
   assign ni_dest  = w_head_dest;
   assign ni_src   = current_node;
   assign ni_data  = w_head_data;

   // RX path: net_ready depends only on stored state, never on rx_pop.
   assign net_ready   = rst && !w_rx_full;
   assign w_net_write = net_valid && net_ready;

   assign rx_valid = rst && !w_rx_empty;
   assign rx_src   = w_rx_rdata[DATA_W +: ADDR_W];
   assign rx_data  = w_rx_rdata[DATA_W-1:0];
   assign w_rx_pop = rx_pop && rx_valid;

   // Network words win the single RX write port; a blocked loopback head
   // simply stays at the TX head, stalling everything queued behind it.
   always_comb begin
      w_rx_sel    = RxSelNone;
      w_rx_wdata  = '0;
      w_rx_push   = 1'b0;
      w_loop_move = 1'b0;
      if (w_net_write) begin
         w_rx_sel = RxSelNet;
      end else if (w_head_local && !w_rx_full) begin
         w_rx_sel = RxSelLoop;
      end
      unique case (w_rx_sel)
         RxSelNet: begin
            w_rx_push  = 1'b1;
            w_rx_wdata = {net_src, net_data};
         end
         RxSelLoop: begin
            w_rx_push   = 1'b1;
            w_loop_move = 1'b1;
            w_rx_wdata  = {current_node, w_head_data};
         end
         default: begin
            w_rx_push = 1'b0;
         end
      endcase
   end

   assign w_tx_pop = (ni_valid && ni_ready) || w_loop_move;

   ni_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_tx_push),
      .wdata (w_tx_wdata),
      .pop   (w_tx_pop),
      .rdata (w_tx_rdata),
      .full  (w_tx_full),
      .empty (w_tx_empty),
      .level (tx_level)
   );

   ni_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_rx_push),
      .wdata (w_rx_wdata),
      .pop   (w_rx_pop),
      .rdata (w_rx_rdata),
      .full  (w_rx_full),
      .empty (w_rx_empty),
      .level (rx_level)
   );

endmodule
